// File: rtl/studio_keypad.sv
// Studio II keypad controller: PS/2 key events -> per-key press state,
// tap stretching, and the OUT-select / EF3-EF4 scan flags.
module studio_keypad #(
  parameter int          NUM_PADS    = 2,
  parameter int          KEYS        = 10,
  parameter int          SEL_PORT    = 2,
  parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         ps2_key,
  input  logic [2:0]          io_n,
  input  logic                io_out,
  input  logic [7:0]          io_dout,
  output logic [NUM_PADS-1:0] ef_n,
  output logic [NUM_PADS-1:0] key_any,
  output logic [3:0]          sel_key
);

  localparam int HOLD_I = int'(HOLD_CYCLES);
  localparam int CW_RAW = $clog2(HOLD_I + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_I);

  logic       shadow;
  logic       toggle;
  logic       make;
  logic       ext;
  logic [7:0] code;

  logic       map_ok;
  logic       map_pad;
  logic [3:0] map_key;
  logic       ev_valid;

  logic [NUM_PADS-1:0][15:0] pressed;

  logic unused_dout;

  assign unused_dout = ^io_dout[7:4];

  assign toggle = ps2_key[10] != shadow;
  assign make   = ps2_key[9];
  assign ext    = ps2_key[8];
  assign code   = ps2_key[7:0];

  // Remember the last toggle level so each flip is seen exactly once
  always_ff @(posedge clk) begin
    shadow <= ps2_key[10];
  end

  // Scancode to pad/key translation; ext must match the table exactly
  always_comb begin
    map_ok  = 1'b1;
    map_pad = 1'b0;
    map_key = 4'd0;
    case ({ext, code})
      9'h045: begin map_pad = 1'b0; map_key = 4'h0; end
      9'h016: begin map_pad = 1'b0; map_key = 4'h1; end
      9'h01E: begin map_pad = 1'b0; map_key = 4'h2; end
      9'h026: begin map_pad = 1'b0; map_key = 4'h3; end
      9'h025: begin map_pad = 1'b0; map_key = 4'h4; end
      9'h02E: begin map_pad = 1'b0; map_key = 4'h5; end
      9'h036: begin map_pad = 1'b0; map_key = 4'h6; end
      9'h03D: begin map_pad = 1'b0; map_key = 4'h7; end
      9'h03E: begin map_pad = 1'b0; map_key = 4'h8; end
      9'h046: begin map_pad = 1'b0; map_key = 4'h9; end
      9'h01C: begin map_pad = 1'b0; map_key = 4'hA; end
      9'h032: begin map_pad = 1'b0; map_key = 4'hB; end
      9'h021: begin map_pad = 1'b0; map_key = 4'hC; end
      9'h023: begin map_pad = 1'b0; map_key = 4'hD; end
      9'h024: begin map_pad = 1'b0; map_key = 4'hE; end
      9'h02B: begin map_pad = 1'b0; map_key = 4'hF; end
      9'h070: begin map_pad = 1'b1; map_key = 4'h0; end
      9'h069: begin map_pad = 1'b1; map_key = 4'h1; end
      9'h072: begin map_pad = 1'b1; map_key = 4'h2; end
      9'h07A: begin map_pad = 1'b1; map_key = 4'h3; end
      9'h06B: begin map_pad = 1'b1; map_key = 4'h4; end
      9'h073: begin map_pad = 1'b1; map_key = 4'h5; end
      9'h074: begin map_pad = 1'b1; map_key = 4'h6; end
      9'h06C: begin map_pad = 1'b1; map_key = 4'h7; end
      9'h075: begin map_pad = 1'b1; map_key = 4'h8; end
      9'h07D: begin map_pad = 1'b1; map_key = 4'h9; end
      9'h071: begin map_pad = 1'b1; map_key = 4'hA; end
      9'h15A: begin map_pad = 1'b1; map_key = 4'hB; end
      9'h14A: begin map_pad = 1'b1; map_key = 4'hC; end
      9'h07C: begin map_pad = 1'b1; map_key = 4'hD; end
      9'h07B: begin map_pad = 1'b1; map_key = 4'hE; end
      9'h079: begin map_pad = 1'b1; map_key = 4'hF; end
      default: map_ok = 1'b0;
    endcase
  end

  assign ev_valid = toggle && map_ok &&
                    (int'(map_key) < KEYS) &&
                    (int'(map_pad) < NUM_PADS);

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    for (genvar k = 0; k < 16; k++) begin : g_key
      if (k < KEYS) begin : g_live
        logic          down;
        logic [CW-1:0] cnt;
        logic          hit;

        assign hit = ev_valid &&
                     (map_pad == 1'(p)) &&
                     (map_key == 4'(k));

        // Key down bit plus release-hold countdown
        always_ff @(posedge clk) begin
          if (reset) begin
            down <= 1'b0;
            cnt  <= '0;
          end else if (hit) begin
            if (make) begin
              down <= 1'b1;
              cnt  <= '0;
            end else if (down) begin
              down <= 1'b0;
              cnt  <= HOLD_C;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end

        assign pressed[p][k] = down | (cnt != '0);
      end else begin : g_dead
        assign pressed[p][k] = 1'b0;
      end
    end
  end

  // Key select latched from OUT on the select port only
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_key <= 4'd0;
    end else if (io_out && (io_n == 3'(SEL_PORT))) begin
      sel_key <= io_dout[3:0];
    end
  end

  // Registered per-pad flags from the current select and key state
  always_ff @(posedge clk) begin
    if (reset) begin
      ef_n    <= '1;
      key_any <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (int'(sel_key) < KEYS) begin
          ef_n[p] <= ~pressed[p][sel_key];
        end else begin
          ef_n[p] <= 1'b1;
        end
        key_any[p] <= |pressed[p];
      end
    end
  end

endmodule

// File: tb/tb_studio_keypad.sv
// Directed bench for studio_keypad with a short hold (4 cycles)
// so release stretching can be observed cycle by cycle.
module tb_studio_keypad;

  logic        clk;
  logic        reset;
  logic [10:0] ps2_key;
  logic [2:0]  io_n;
  logic        io_out;
  logic [7:0]  io_dout;
  logic [1:0]  ef_n;
  logic [1:0]  key_any;
  logic [3:0]  sel_key;

  int tests;
  int fails;

  studio_keypad #(
    .NUM_PADS(2),
    .KEYS(10),
    .SEL_PORT(2),
    .HOLD_CYCLES(16'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_key(ps2_key),
    .io_n(io_n),
    .io_out(io_out),
    .io_dout(io_dout),
    .ef_n(ef_n),
    .key_any(key_any),
    .sel_key(sel_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic mk, input logic ex, input logic [7:0] c);
    ps2_key = {~ps2_key[10], mk, ex, c};
    tick();
  endtask

  task automatic sel_write(input logic [2:0] n, input logic [7:0] d);
    io_n    = n;
    io_dout = d;
    io_out  = 1'b1;
    tick();
    io_out  = 1'b0;
  endtask

  task automatic test_reset();
    ps2_key = 11'h400;
    reset   = 1'b1;
    ticks(2);
    reset   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      tests++;
      if (ef_n !== 2'b11 || key_any !== 2'b00 || sel_key !== 4'd0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d ef_n=%b key_any=%b sel=%h want 11/00/0",
                 i, ef_n, key_any, sel_key);
      end
    end
  endtask

  task automatic test_press_release();
    sel_write(3'd2, 8'h05);
    tests++;
    if (sel_key !== 4'h5) begin
      fails++;
      $display("FAIL sel_write got=%h want=5", sel_key);
    end
    send(1'b1, 1'b0, 8'h2E);
    tests++;
    if (ef_n !== 2'b11) begin
      fails++;
      $display("FAIL press_edge1 got=%b want=11", ef_n);
    end
    tick();
    tests++;
    if (ef_n !== 2'b10 || key_any !== 2'b01) begin
      fails++;
      $display("FAIL press_edge2 ef_n=%b key_any=%b want 10/01", ef_n, key_any);
    end
    send(1'b0, 1'b0, 8'h2E);
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++;
      if (ef_n !== 2'b10) begin
        fails++;
        $display("FAIL hold_low E+%0d got=%b want=10", i, ef_n);
      end
    end
    tick();
    tests++;
    if (ef_n !== 2'b11 || key_any !== 2'b00) begin
      fails++;
      $display("FAIL hold_end ef_n=%b key_any=%b want 11/00", ef_n, key_any);
    end
  endtask

  task automatic test_ext_and_unmapped();
    sel_write(3'd2, 8'h08);
    send(1'b1, 1'b1, 8'h75);
    tick();
    tests++;
    if (ef_n !== 2'b11 || key_any !== 2'b00) begin
      fails++;
      $display("FAIL ext_arrow ef_n=%b key_any=%b want 11/00", ef_n, key_any);
    end
    send(1'b1, 1'b0, 8'h1A);
    tick();
    tests++;
    if (ef_n !== 2'b11 || key_any !== 2'b00) begin
      fails++;
      $display("FAIL unmapped ef_n=%b key_any=%b want 11/00", ef_n, key_any);
    end
    send(1'b1, 1'b0, 8'h75);
    tick();
    tests++;
    if (ef_n !== 2'b01 || key_any !== 2'b10) begin
      fails++;
      $display("FAIL numpad8 ef_n=%b key_any=%b want 01/10", ef_n, key_any);
    end
    send(1'b0, 1'b0, 8'h75);
    ticks(6);
    tests++;
    if (ef_n !== 2'b11 || key_any !== 2'b00) begin
      fails++;
      $display("FAIL numpad8_rel ef_n=%b key_any=%b want 11/00", ef_n, key_any);
    end
  endtask

  task automatic test_multi_key();
    sel_write(3'd2, 8'h05);
    send(1'b1, 1'b0, 8'h26);
    send(1'b1, 1'b0, 8'h2E);
    send(1'b0, 1'b0, 8'h26);
    ticks(6);
    tests++;
    if (ef_n !== 2'b10 || key_any !== 2'b01) begin
      fails++;
      $display("FAIL multi_key5 ef_n=%b key_any=%b want 10/01", ef_n, key_any);
    end
    sel_write(3'd2, 8'h03);
    tick();
    tests++;
    if (ef_n !== 2'b11) begin
      fails++;
      $display("FAIL multi_key3 got=%b want=11", ef_n);
    end
  endtask

  task automatic test_other_port();
    sel_write(3'd3, 8'h07);
    tests++;
    if (sel_key !== 4'h3) begin
      fails++;
      $display("FAIL other_port got=%h want=3", sel_key);
    end
    io_n    = 3'd2;
    io_dout = 8'h09;
    tick();
    tests++;
    if (sel_key !== 4'h3) begin
      fails++;
      $display("FAIL no_strobe got=%h want=3", sel_key);
    end
    send(1'b0, 1'b0, 8'h2E);
    ticks(6);
  endtask

  task automatic test_keys_limit();
    sel_write(3'd2, 8'h0C);
    tests++;
    if (sel_key !== 4'hC) begin
      fails++;
      $display("FAIL sel_c got=%h want=c", sel_key);
    end
    send(1'b1, 1'b0, 8'h1C);
    tick();
    tests++;
    if (ef_n !== 2'b11 || key_any !== 2'b00) begin
      fails++;
      $display("FAIL key_a_ignored ef_n=%b key_any=%b want 11/00", ef_n, key_any);
    end
    send(1'b0, 1'b0, 8'h1C);
  endtask

  task automatic test_simultaneous();
    io_n    = 3'd2;
    io_dout = 8'h04;
    io_out  = 1'b1;
    send(1'b1, 1'b0, 8'h25);
    io_out  = 1'b0;
    tests++;
    if (sel_key !== 4'h4 || ef_n !== 2'b11) begin
      fails++;
      $display("FAIL simul_e sel=%h ef_n=%b want 4/11", sel_key, ef_n);
    end
    tick();
    tests++;
    if (ef_n !== 2'b10) begin
      fails++;
      $display("FAIL simul_e1 got=%b want=10", ef_n);
    end
    send(1'b0, 1'b0, 8'h25);
    ticks(6);
  endtask

  task automatic test_both_pads();
    sel_write(3'd2, 8'h09);
    send(1'b1, 1'b0, 8'h46);
    tick();
    tests++;
    if (ef_n !== 2'b10) begin
      fails++;
      $display("FAIL pad0_key9 got=%b want=10", ef_n);
    end
    send(1'b1, 1'b0, 8'h7D);
    tick();
    tests++;
    if (ef_n !== 2'b00 || key_any !== 2'b11) begin
      fails++;
      $display("FAIL both_key9 ef_n=%b key_any=%b want 00/11", ef_n, key_any);
    end
    send(1'b0, 1'b0, 8'h46);
    ticks(6);
    tests++;
    if (ef_n !== 2'b01 || key_any !== 2'b10) begin
      fails++;
      $display("FAIL pad1_only ef_n=%b key_any=%b want 01/10", ef_n, key_any);
    end
    send(1'b0, 1'b0, 8'h7D);
    ticks(6);
  endtask

  task automatic test_back_to_back();
    sel_write(3'd2, 8'h02);
    send(1'b1, 1'b0, 8'h16);
    send(1'b1, 1'b0, 8'h1E);
    tick();
    tests++;
    if (ef_n !== 2'b10 || key_any !== 2'b01) begin
      fails++;
      $display("FAIL b2b ef_n=%b key_any=%b want 10/01", ef_n, key_any);
    end
    sel_write(3'd2, 8'h01);
    tick();
    tests++;
    if (ef_n !== 2'b10) begin
      fails++;
      $display("FAIL b2b_key1 got=%b want=10", ef_n);
    end
    send(1'b0, 1'b0, 8'h16);
    send(1'b0, 1'b0, 8'h1E);
    ticks(6);
    tests++;
    if (ef_n !== 2'b11 || key_any !== 2'b00) begin
      fails++;
      $display("FAIL b2b_rel ef_n=%b key_any=%b want 11/00", ef_n, key_any);
    end
  endtask

  task automatic test_reset_hold();
    sel_write(3'd2, 8'h05);
    send(1'b1, 1'b0, 8'h2E);
    send(1'b0, 1'b0, 8'h2E);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (ef_n !== 2'b11 || key_any !== 2'b00 || sel_key !== 4'd0) begin
      fails++;
      $display("FAIL reset_hold ef_n=%b key_any=%b sel=%h want 11/00/0",
               ef_n, key_any, sel_key);
    end
    sel_write(3'd2, 8'h05);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (ef_n !== 2'b11 || key_any !== 2'b00) begin
        fails++;
        $display("FAIL no_resume cyc=%0d ef_n=%b key_any=%b want 11/00",
                 i, ef_n, key_any);
      end
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    ps2_key = 11'h400;
    io_n    = 3'd0;
    io_out  = 1'b0;
    io_dout = 8'h00;
    test_reset();
    test_press_release();
    test_ext_and_unmapped();
    test_multi_key();
    test_other_port();
    test_keys_limit();
    test_simultaneous();
    test_both_pads();
    test_back_to_back();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/studio_keypad.md
Name: studio_keypad

Overview:
- Parametrised keypad controller for the Studio II core. Translates PS/2 key events into per-key press state for up to 2 hex keypads.
- Tracks press and release independently for every key, so simultaneous keys and releases are handled correctly.
- Stretches short taps so the CPU's polling loop can see them.
- Reproduces the Studio II scan scheme: the CPU writes a key number with OUT on port SEL_PORT, then samples EF3 (pad 0) or EF4 (pad 1), which go low when the selected key is down on that pad.

Parameters:
- NUM_PADS, 2, number of keypads (1 or 2)
- KEYS, 10, keys per pad (10 = digits 0-9, 16 = hex 0-F)
- SEL_PORT, 2, io_n value that latches the key select
- HOLD_CYCLES, 16'd50000, clocks a key stays pressed after release; 0 = no stretch

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ps2_key  in  11  [10] event toggle, [9] 1 = make / 0 = break, [8] extended, [7:0] scancode
- io_n  in  3  CPU N lines
- io_out  in  1  CPU output strobe, one cycle per OUT
- io_dout  in  8  CPU output data
- ef_n  out  NUM_PADS  active-low key flags; bit0 drives EF3, bit1 drives EF4
- key_any  out  NUM_PADS  1 = any key on that pad effectively pressed
- sel_key  out  4  currently latched key select

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - ef_n all 1, key_any all 0, sel_key 0.
  - All down bits 0, all hold counters 0.
  - Strobe shadow loaded with ps2_key[10], so no spurious event leaves reset.
- Reset asserted mid-press or mid-hold clears all state on that edge.
- Event detect: an event occurs in a cycle where ps2_key[10] != shadow. The shadow updates every cycle.
- Key map, pad 0 (ext = 0 only):
  - 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - When KEYS=16: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
- Key map, pad 1, numpad:
  - ext = 0: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - When KEYS=16: 71=A, ext 5A=B, ext 4A=C, 7C=D, 7B=E, 79=F.
- Ignored events (no state change):
  - Unmapped codes.
  - Codes whose ext bit does not match the table (e.g. arrow keys sharing numpad codes).
  - Keys >= KEYS.
  - Pad index >= NUM_PADS.
- Per-key state: down bit plus hold counter, width clog2(HOLD_CYCLES+1), minimum 1.
  - Make: down=1, cnt=0.
  - Break when down=1: down=0, cnt=HOLD_CYCLES.
  - Break when down=0: no change; no hold is started.
  - cnt decrements by 1 each cycle while nonzero and the key is not receiving an event; it saturates at 0.
  - Effective pressed = down | (cnt != 0).
  - Re-press during hold: down=1, cnt=0.
- Select latch: on an edge with io_out=1 and io_n==SEL_PORT, sel_key <= io_dout[3:0]. Other ports are ignored.
- Flags, registered:
  - ef_n[p] = ~pressed_eff[p][sel_key], computed from the current sel_key.
  - If sel_key >= KEYS, ef_n[p] = 1.
  - key_any[p] = OR of pressed_eff[p][*], registered.
- Latency:
  - Toggle presented before edge E: down/cnt update at E; ef_n/key_any change at E+1.
  - Select write at E: sel_key changes at E; ef_n reflects it at E+1.
- Simultaneous select write and key event in one cycle: both apply at E; ef_n at E+1 uses the new sel and the new key state.
- Both pads with the same key selected: flags are independent per pad.

Test Plan:
- Reset with ps2_key[10]=1 held high, then no toggle -> ef_n=2'b11, key_any=0, sel_key=0 for 100 cycles.
- OUT io_n=2 data 8'h05; toggle ps2_key with {1,0,8'h2E} -> ef_n=2'b10 exactly 2 edges after the toggle; key_any=2'b01.
- With HOLD_CYCLES=4: press then break code 2E on key 5 -> ef_n[0] stays 0 for 4 cycles after the break edge, then returns to 1.
- Extended 75 (up arrow) with sel=8 -> no change. Plain 75 -> ef_n[1]=0.
- Pad 0 keys 3 and 5 both pressed, then release 3 -> with sel=5, ef_n[0] stays 0.
- OUT io_n=3 data 8'h07 -> sel_key unchanged.
- KEYS=10, sel=8'h0C with pad 0 key A mapped code 1C -> ignored; ef_n[0]=1.
- Reset asserted during a hold -> ef_n=1 next edge; hold does not resume.
